pu_pio_master: RTL and testbench
================================

// Module: pu_pio_master
// PURPOSE
//  Initiator end of the PU PIO register bus. Accepts single read/write requests from the host
//  management bridge and drives reg_bs/reg_rd/reg_wr/reg_addr/reg_din toward the PU PIO
//  responder. Waits for pio_ack (write) or pio_rvalid+pio_rdata (read) and returns one response
//  per request. Flags an error on timeout. One transaction is outstanding at a time.
// PARAMETERS
//  TO_TICKS  255  timeout, in clk_div ticks, counted in WAIT; must fit in TO_W bits
//  TO_W      8    timeout counter width
// PORTS
//  clk          in   1          core clock
//  `RESET_SIG   in   1          asynchronous, active-low reset
//  clk_div      in   1          slow-tick enable, 1 clk wide; responder updates ack/rvalid on it
//  req_valid    in   1          host request valid
//  req_ready    out  1          master idle, can accept a request
//  req_wr       in   1          1=write, 0=read
//  req_addr     in   PIO_NBITS  register address
//  req_wdata    in   PIO_NBITS  write data
//  rsp_valid    out  1          response strobe, 1 clk wide
//  rsp_err      out  1          qualifies rsp_valid: timeout occurred
//  rsp_rdata    out  PIO_NBITS  read data; 0 for writes and on error
//  reg_bs       out  1          bus select, held for the whole transaction
//  reg_wr       out  1          write command pulse
//  reg_rd       out  1          read command pulse
//  reg_addr     out  PIO_NBITS  address, stable while reg_bs=1
//  reg_din      out  PIO_NBITS  write data, stable while reg_bs=1
//  pio_ack      in   1          write completion from responder
//  pio_rvalid   in   1          read completion from responder
//  pio_rdata    in   PIO_NBITS  read data, valid with pio_rvalid
// BEHAVIOUR
//  Reset: every output is 0, state=IDLE, timeout counter=0. req_ready is 0 during reset.
//  All outputs are registered, except req_ready = (state==IDLE).
//  IDLE: on req_valid&req_ready, latch wr/addr/wdata into reg_addr/reg_din and set reg_bs=1.
//   Go to CMD.
//  CMD (1 clk): reg_rd=~wr or reg_wr=wr, pulsed for exactly one clk; reg_bs stays 1.
//   Clear the counter and go to WAIT.
//  WAIT: on each clk_div tick the counter increments.
//   Write completes when pio_ack=1. Read completes when pio_rvalid=1; capture pio_rdata.
//   Completion is sampled every clk, independent of clk_div.
//   pio_ack during a read is ignored. pio_rvalid during a write is ignored.
//   Timeout: on the clk_div tick where the counter reaches TO_TICKS with no completion, timeout.
//   On completion or timeout, go to RESP. Completion and timeout in the same clk: completion wins.
//  RESP (1 clk): rsp_valid=1, rsp_err=timeout, rsp_rdata=captured data (0 if write or err).
//   reg_bs, reg_addr, reg_din drop to 0. Go to DRAIN.
//  DRAIN: wait for a clk_div tick with pio_ack=0 and pio_rvalid=0, so stale responder flags
//   cannot complete the next transaction. Then go to IDLE.
//  Latency: request accept to command pulse is 2 clk. Back-to-back throughput is bounded by DRAIN.
//  req_valid while req_ready=0 is not accepted; the host holds it.
//  rsp_* are not back-pressured; the host must sink rsp_valid.
//  Reset mid-transaction: immediate return to IDLE with outputs 0. No response is issued.
//  Counter saturates at TO_TICKS and never wraps.
// STRUCTURE
//  Shared defines header: PIO_NBITS / PIO_RANGE (existing) and the state encodings
//   PIOM_IDLE/CMD/WAIT/RESP/DRAIN (3 bits).
//  Single module. The timeout counter is inline; no sub-module is warranted.
// TESTING
//  Responder model acks 3 clk_div ticks after cmd. Write addr=0x10, data=0xA5A5A5A5 ->
//   one reg_wr pulse; reg_din stable until RESP; rsp_valid with err=0, rdata=0.
//  Read addr=0x20, model returns pio_rvalid with 0xDEADBEEF -> exactly one reg_rd pulse;
//   rsp_rdata=0xDEADBEEF, err=0.
//  Read to unmapped addr, responder silent -> rsp_err=1 and rdata=0 after exactly TO_TICKS
//   clk_div ticks (set TO_TICKS=4 for the test).
//  Back-to-back write then read, model holds pio_ack high 2 extra ticks -> read not issued until
//   DRAIN sees ack=0; read completes on rvalid, not on the stale ack.
//  Assert `RESET_SIG low in WAIT, then release -> all outputs 0, no rsp_valid;
//   the next request completes normally.
//  req_valid held through a busy period -> accepted only when req_ready=1; one response per request.

Source files
------------

// File: rtl/pu_pio_master_pkg.sv
// Shared definitions for the PU PIO register-bus initiator: bus width and the
// 3-bit encoding of the master transaction states.
package pu_pio_master_pkg;

    localparam int PIO_NBITS = 32;

    typedef logic [PIO_NBITS-1:0] pio_word_t;

    typedef enum logic [2:0] {
        PIOM_IDLE  = 3'd0,
        PIOM_CMD   = 3'd1,
        PIOM_WAIT  = 3'd2,
        PIOM_RESP  = 3'd3,
        PIOM_DRAIN = 3'd4
    } piom_state_t;

endpackage

// File: rtl/pu_pio_master.sv
// PU PIO register-bus initiator: issues one host read/write at a time toward the
// PIO responder, waits for ack/rvalid or a clk_div-based timeout, returns one response.
module pu_pio_master
    import pu_pio_master_pkg::*;
#(
    parameter int TO_TICKS = 255,
    parameter int TO_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_div,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [PIO_NBITS-1:0] req_addr,
    input  logic [PIO_NBITS-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [PIO_NBITS-1:0] rsp_rdata,
    output logic                 reg_bs,
    output logic                 reg_wr,
    output logic                 reg_rd,
    output logic [PIO_NBITS-1:0] reg_addr,
    output logic [PIO_NBITS-1:0] reg_din,
    input  logic                 pio_ack,
    input  logic                 pio_rvalid,
    input  logic [PIO_NBITS-1:0] pio_rdata
);

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TO_TICKS - 1);
    localparam logic [TO_W-1:0] CNT_MAX  = TO_W'(TO_TICKS);

    piom_state_t     state_q, state_d;
    logic            wr_q, wr_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            bs_q, bs_d;
    logic            regwr_q, regwr_d;
    logic            regrd_q, regrd_d;
    pio_word_t       addr_q, addr_d;
    pio_word_t       din_q, din_d;
    logic            rspv_q, rspv_d;
    logic            rsperr_q, rsperr_d;
    pio_word_t       rsprdata_q, rsprdata_d;

    logic            done_w;
    logic            timeout_w;

    // Only the completion flag matching the transaction type counts.
    assign done_w    = wr_q ? pio_ack : pio_rvalid;
    assign timeout_w = clk_div && (cnt_q >= CNT_LAST);

    assign req_ready = rst_n && (state_q == PIOM_IDLE);
    assign rsp_valid = rspv_q;
    assign rsp_err   = rsperr_q;
    assign rsp_rdata = rsprdata_q;
    assign reg_bs    = bs_q;
    assign reg_wr    = regwr_q;
    assign reg_rd    = regrd_q;
    assign reg_addr  = addr_q;
    assign reg_din   = din_q;

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        bs_d       = bs_q;
        addr_d     = addr_q;
        din_d      = din_q;
        regwr_d    = 1'b0;
        regrd_d    = 1'b0;
        rspv_d     = 1'b0;
        rsperr_d   = 1'b0;
        rsprdata_d = '0;

        case (state_q)
            PIOM_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    din_d   = req_wdata;
                    bs_d    = 1'b1;
                    state_d = PIOM_CMD;
                end
            end
            PIOM_CMD: begin
                regwr_d = wr_q;
                regrd_d = ~wr_q;
                cnt_d   = '0;
                state_d = PIOM_WAIT;
            end
            PIOM_WAIT: begin
                if (clk_div && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + TO_W'(1);
                end
                // Completion takes priority over a timeout on the same cycle.
                if (done_w || timeout_w) begin
                    rspv_d     = 1'b1;
                    rsperr_d   = ~done_w;
                    rsprdata_d = (done_w && !wr_q) ? pio_rdata : '0;
                    bs_d       = 1'b0;
                    addr_d     = '0;
                    din_d      = '0;
                    state_d    = PIOM_RESP;
                end
            end
            PIOM_RESP: begin
                state_d = PIOM_DRAIN;
            end
            PIOM_DRAIN: begin
                // Stale responder flags must be seen low on a tick before re-arming.
                if (clk_div && !pio_ack && !pio_rvalid) begin
                    state_d = PIOM_IDLE;
                end
            end
            default: begin
                state_d = PIOM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PIOM_IDLE;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            bs_q       <= 1'b0;
            regwr_q    <= 1'b0;
            regrd_q    <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            rspv_q     <= 1'b0;
            rsperr_q   <= 1'b0;
            rsprdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            bs_q       <= bs_d;
            regwr_q    <= regwr_d;
            regrd_q    <= regrd_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rspv_q     <= rspv_d;
            rsperr_q   <= rsperr_d;
            rsprdata_q <= rsprdata_d;
        end
    end

endmodule

// File: tb/tb_pu_pio_master.sv
// Bench for pu_pio_master: behavioural PIO responder plus a transaction-level
// reference model of the expected host responses (directed table, then random traffic).
module tb_pu_pio_master;
    import pu_pio_master_pkg::*;

    localparam int TO_TICKS = 4;
    localparam int TO_W     = 8;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      clk_div;
    logic      req_valid;
    logic      req_ready;
    logic      req_wr;
    pio_word_t req_addr;
    pio_word_t req_wdata;
    logic      rsp_valid;
    logic      rsp_err;
    pio_word_t rsp_rdata;
    logic      reg_bs;
    logic      reg_wr;
    logic      reg_rd;
    pio_word_t reg_addr;
    pio_word_t reg_din;
    logic      pio_ack;
    logic      pio_rvalid;
    pio_word_t pio_rdata;

    always #5 clk = ~clk;

    pu_pio_master #(.TO_TICKS(TO_TICKS), .TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rst_n), .clk_div(clk_div),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .reg_bs(reg_bs), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_addr(reg_addr), .reg_din(reg_din),
        .pio_ack(pio_ack), .pio_rvalid(pio_rvalid), .pio_rdata(pio_rdata)
    );

    typedef struct {
        logic      wr;
        pio_word_t addr;
        pio_word_t wdata;
        logic      err;
        pio_word_t rdata;
        int        ticks;
    } exp_t;

    typedef struct {
        int delay;
        int hold;
    } cfg_t;

    typedef struct {
        exp_t e;
        cfg_t c;
    } vec_t;

    int        checks = 0;
    int        errors = 0;
    exp_t      expQ[$];
    cfg_t      cfgQ[$];
    pio_word_t modelMem[pio_word_t];
    pio_word_t respMem[pio_word_t];

    // Monitor / responder state, shared with the host only for observation.
    bit        inWait = 0;
    int        waitTicks = 0;
    int        pulseCnt = 0;
    bit        stableBad = 0;
    bit        bsPrev = 0;
    pio_word_t latAddr, latDin;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic bit isUnmapped(input pio_word_t a);
        return a[7:4] == 4'hF;
    endfunction

    function automatic pio_word_t regDefault(input pio_word_t a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic vec_t mkVec(input logic wr, input pio_word_t addr, input pio_word_t wdata,
                                   input int delay, input int hold, input logic err,
                                   input pio_word_t rdata, input int ticks);
        vec_t v;
        v.e = '{wr: wr, addr: addr, wdata: wdata, err: err, rdata: rdata, ticks: ticks};
        v.c = '{delay: delay, hold: hold};
        return v;
    endfunction

    // Host-level model: silent responder -> timeout after TO_TICKS; otherwise
    // completion after the responder delay, reads return the last write.
    function automatic exp_t predict(input logic wr, input pio_word_t addr,
                                     input pio_word_t wdata, input int delay);
        exp_t e;
        e = '{wr: wr, addr: addr, wdata: wdata, err: 1'b0, rdata: '0, ticks: delay};
        if (isUnmapped(addr)) begin
            e.err   = 1'b1;
            e.ticks = TO_TICKS;
        end else if (wr) begin
            modelMem[addr] = wdata;
        end else begin
            e.rdata = modelMem.exists(addr) ? modelMem[addr] : regDefault(addr);
        end
        return e;
    endfunction

    task automatic applyStimulus(input exp_t e, input cfg_t c);
        int budget;
        req_valid = 1'b1;
        req_wr    = e.wr;
        req_addr  = e.addr;
        req_wdata = e.wdata;
        budget    = 0;
        while (!req_ready && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: req_ready=%0b required 1", req_ready);
        end else begin
            expQ.push_back(e);
            cfgQ.push_back(c);
            @(negedge clk);
        end
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic waitDone();
        int budget;
        budget = 0;
        while (!(expQ.size() == 0 && req_ready) && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("drain_complete", 128'(expQ.size()), 128'(0));
    endtask

    // Combined clk_div generator, bus monitor and PIO responder, all at negedge.
    initial begin
        bit        tickSeen, newTick, newPulse, pending, flagOn, curWr;
        int        gapLeft, tickCnt, holdLeft, curDelay, curHold;
        pio_word_t curAddr, curDin;
        exp_t      e;
        cfg_t      c;
        clk_div = 1'b0; pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0;
        gapLeft = 2; pending = 0; flagOn = 0; tickCnt = 0; holdLeft = 0;
        curDelay = 0; curHold = 0; curWr = 0; curAddr = '0; curDin = '0;
        forever begin
            @(negedge clk);
            tickSeen = clk_div;
            newPulse = 0;
            if (!rst_n) begin
                pending = 0; flagOn = 0; inWait = 0; pulseCnt = 0; stableBad = 0; bsPrev = 0;
                pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0; clk_div = 1'b0;
            end else begin
                if (inWait && tickSeen) waitTicks++;
                if (reg_bs) begin
                    if (!bsPrev) begin
                        latAddr = reg_addr;
                        latDin  = reg_din;
                    end else if (reg_addr !== latAddr || reg_din !== latDin) begin
                        stableBad = 1;
                    end
                end
                bsPrev = reg_bs;
                if (reg_wr || reg_rd) begin
                    pulseCnt++;
                    if (!inWait) begin
                        inWait    = 1;
                        waitTicks = 0;
                        newPulse  = 1;
                    end
                end
                if (newPulse) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL spurious_cmd: pulse with no request outstanding");
                    end else begin
                        e = expQ[0];
                        checkOutput("cmd_bus", 128'({reg_bs, reg_wr, reg_rd, reg_addr, reg_din}),
                                    128'({1'b1, e.wr, ~e.wr, e.addr, e.wdata}));
                    end
                    checkOutput("no_stale_flags", 128'({pio_ack, pio_rvalid}), 128'(0));
                end
                if (rsp_valid) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL spurious_rsp: rsp_valid=1 with no request outstanding");
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("rsp_data", 128'({rsp_err, rsp_rdata}), 128'({e.err, e.rdata}));
                        checkOutput("rsp_ticks", 128'(waitTicks), 128'(e.ticks));
                        checkOutput("cmd_pulses", 128'(pulseCnt), 128'(1));
                        checkOutput("bus_released", 128'({reg_bs, reg_addr, reg_din}), 128'(0));
                        checkOutput("bus_stable", 128'(stableBad), 128'(0));
                    end
                    inWait = 0; pulseCnt = 0; stableBad = 0;
                end

                if (gapLeft == 0) begin
                    newTick = 1;
                    gapLeft = $urandom_range(4, 1);
                end else begin
                    newTick = 0;
                    gapLeft--;
                end

                if (newPulse) begin
                    if (cfgQ.size() != 0) c = cfgQ.pop_front();
                    else c = '{delay: 1, hold: 0};
                    curDelay = c.delay;
                    curHold  = c.hold;
                    curWr    = reg_wr;
                    curAddr  = reg_addr;
                    curDin   = reg_din;
                    pending  = !isUnmapped(reg_addr);
                    tickCnt  = 0;
                end
                if (newTick) begin
                    if (flagOn) begin
                        holdLeft--;
                        if (holdLeft == 0) begin
                            flagOn = 0; pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0;
                        end
                    end
                    if (pending) begin
                        tickCnt++;
                        if (tickCnt == curDelay) begin
                            pending  = 0;
                            flagOn   = 1;
                            holdLeft = 1 + curHold;
                            if (curWr) begin
                                pio_ack = 1'b1;
                                respMem[curAddr] = curDin;
                            end else begin
                                pio_rvalid = 1'b1;
                                pio_rdata  = respMem.exists(curAddr) ? respMem[curAddr]
                                                                     : regDefault(curAddr);
                            end
                        end
                    end
                end
                clk_div = newTick;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[9];
        exp_t e;
        cfg_t c;
        int   budget;
        logic wr;
        pio_word_t addr;

        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        respMem[32'h20] = 32'hDEADBEEF;

        vecs[0] = mkVec(1'b1, 32'h10, 32'hA5A5A5A5, 3, 0, 1'b0, 32'h0,        3);
        vecs[1] = mkVec(1'b0, 32'h20, 32'h0,        3, 0, 1'b0, 32'hDEADBEEF, 3);
        vecs[2] = mkVec(1'b0, 32'hF0, 32'h0,        3, 0, 1'b1, 32'h0,        TO_TICKS);
        vecs[3] = mkVec(1'b1, 32'h30, 32'h12345678, 4, 0, 1'b0, 32'h0,        4);
        vecs[4] = mkVec(1'b1, 32'h40, 32'hCAFEF00D, 3, 2, 1'b0, 32'h0,        3);
        vecs[5] = mkVec(1'b0, 32'h40, 32'h0,        3, 0, 1'b0, 32'hCAFEF00D, 3);
        vecs[6] = mkVec(1'b0, 32'h10, 32'h0,        1, 0, 1'b0, 32'hA5A5A5A5, 1);
        vecs[7] = mkVec(1'b1, 32'hF4, 32'h11110000, 2, 0, 1'b1, 32'h0,        TO_TICKS);
        vecs[8] = mkVec(1'b0, 32'h30, 32'h0,        2, 1, 1'b0, 32'h12345678, 2);

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_outputs",
                    128'({req_ready, rsp_valid, rsp_err, rsp_rdata, reg_bs, reg_wr, reg_rd,
                          reg_addr, reg_din}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("ready_after_reset", 128'(req_ready), 128'(1));

        $display("[TB] directed table, requests held back-to-back");
        for (int i = 0; i < 9; i++) applyStimulus(vecs[i].e, vecs[i].c);
        waitDone();

        $display("[TB] reset while waiting for completion");
        applyStimulus('{wr: 1'b0, addr: 32'h24, wdata: 32'h0, err: 1'b0, rdata: 32'h0, ticks: 3},
                      '{delay: 3, hold: 0});
        budget = 0;
        while (!inWait && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("reached_wait", 128'(inWait), 128'(1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expQ.delete();
        cfgQ.delete();
        checkOutput("reset_mid_outputs",
                    128'({req_ready, rsp_valid, rsp_err, rsp_rdata, reg_bs, reg_wr, reg_rd,
                          reg_addr, reg_din}), 128'(0));
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("reset_quiet", 128'({rsp_valid, reg_bs, req_ready}), 128'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus('{wr: 1'b1, addr: 32'h50, wdata: 32'h0BADF00D, err: 1'b0, rdata: 32'h0,
                        ticks: 2}, '{delay: 2, hold: 0});
        applyStimulus('{wr: 1'b0, addr: 32'h50, wdata: 32'h0, err: 1'b0, rdata: 32'h0BADF00D,
                        ticks: 3}, '{delay: 3, hold: 0});
        waitDone();

        $display("[TB] random traffic against reference model");
        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom_range(1, 0));
            addr = 32'h100 | (pio_word_t'($urandom_range(15, 0)) << 4);
            c    = '{delay: $urandom_range(TO_TICKS, 1), hold: $urandom_range(2, 0)};
            e    = predict(wr, addr, $urandom, c.delay);
            applyStimulus(e, c);
            if ($urandom_range(3, 0) == 0) repeat ($urandom_range(20, 1)) @(negedge clk);
        end
        waitDone();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
